// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the convolution window address generator.
// Holds the sweep FSM encoding and default field widths.
package conv_ctrl_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FIN
  } state_e;

endpackage

// File: rtl/window_tap_counter.sv
// Tap index within one window.
// Counts on enable and wraps to zero after reaching the limit.
module window_tap_counter
  import conv_ctrl_pkg::*;
#(
  parameter int W = DEF_ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] r_count;

  assign o_count = r_count;
  assign o_wrap  = i_en && (r_count == i_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_wrap ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/window_addr_gen.sv
// Sliding-window read address generator for a 1-D convolution.
// Emits base+tap beats per window until the next window overruns.
module window_addr_gen
  import conv_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] filter_size,
  input  logic [ADDR_W-1:0] stride,
  input  logic [ADDR_W-1:0] ifmap_len,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] filter_addr,
  output logic              window_last,
  output logic [CNT_W-1:0]  window_count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int EW = ADDR_W + 2;

  state_e            r_state;
  logic [ADDR_W-1:0] r_fsize;
  logic [ADDR_W-1:0] r_stride;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done;
  logic              r_err;

  logic              w_run;
  logic              w_fire;
  logic              w_wrap;
  logic [ADDR_W-1:0] w_tap;
  logic [ADDR_W-1:0] w_limit;
  logic [EW-1:0]     w_next_base;
  logic [EW-1:0]     w_next_end;
  logic              w_fits;
  logic              w_degen;

  assign w_run   = (r_state == S_RUN);
  assign w_fire  = w_run && rd_ready;
  assign w_limit = r_fsize - 1'b1;

  // Extra headroom so base+stride+size never aliases.
  assign w_next_base = EW'(r_base) + EW'(r_stride);
  assign w_next_end  = w_next_base + EW'(r_fsize);
  assign w_fits      = (w_next_end <= EW'(r_len));
  assign w_degen     = (r_fsize == '0) || (r_fsize > r_len);

  window_tap_counter #(
    .W (ADDR_W)
  ) u_tap (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (r_state == S_LOAD),
    .i_en    (w_fire),
    .i_limit (w_limit),
    .o_count (w_tap),
    .o_wrap  (w_wrap)
  );

  assign rd_valid     = w_run;
  assign rd_addr      = r_base + w_tap;
  assign filter_addr  = w_tap;
  assign window_last  = w_run && (w_tap == w_limit);
  assign window_count = r_cnt;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign err          = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_fsize  <= '0;
      r_stride <= '0;
      r_len    <= '0;
      r_base   <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_fsize  <= filter_size;
            r_stride <= (stride == '0) ?
                        ADDR_W'(1) : stride;
            r_len    <= ifmap_len;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_base <= '0;
          if (w_degen) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_wrap) begin
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            if (w_fits) begin
              r_base <= w_next_base[ADDR_W-1:0];
            end else begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_addr_gen.sv
// Self-checking bench: directed scenarios plus random sweeps
// compared beat by beat against a window-list reference model.
module tb_window_addr_gen;

  localparam int AW = 5;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] filter_size = '0;
  logic [AW-1:0] stride = '0;
  logic [AW-1:0] ifmap_len = '0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] filter_addr;
  logic          window_last;
  logic [CW-1:0] window_count;
  logic          busy;
  logic          done;
  logic          err;

  int n_cmp = 0;
  int n_mis = 0;

  int q_addr[$];
  int q_fa[$];
  int q_last[$];
  int exp_cnt;
  bit exp_err;

  always #5 clk = ~clk;

  window_addr_gen #(
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .filter_size  (filter_size),
    .stride       (stride),
    .ifmap_len    (ifmap_len),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_addr      (rd_addr),
    .filter_addr  (filter_addr),
    .window_last  (window_last),
    .window_count (window_count),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Reference: list every window base, then every tap in it.
  task automatic build_model(input int f, input int s,
                             input int len);
    int se;
    int nwin;
    q_addr.delete();
    q_fa.delete();
    q_last.delete();
    exp_err = (f == 0) || (f > len);
    se = (s == 0) ? 1 : s;
    nwin = 0;
    if (!exp_err) begin
      for (int b = 0; b + f <= len; b += se) begin
        for (int t = 0; t < f; t++) begin
          q_addr.push_back(b + t);
          q_fa.push_back(t);
          q_last.push_back(t == f - 1 ? 1 : 0);
        end
        nwin++;
      end
    end
    exp_cnt = (nwin > 255) ? 255 : nwin;
  endtask

  function automatic bit ready_of(input int mode,
                                  input int ph);
    case (mode)
      0:       return 1'b1;
      1:       return (ph % 4 == 0) || (ph % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(rd_valid), 0);
    check({tag, "_addr"}, 32'(rd_addr), 0);
    check({tag, "_faddr"}, 32'(filter_addr), 0);
    check({tag, "_last"}, 32'(window_last), 0);
    check({tag, "_cnt"}, 32'(window_count), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic launch(input int f, input int s,
                        input int len);
    @(negedge clk);
    start = 1'b1;
    filter_size = AW'(f);
    stride = AW'(s);
    ifmap_len = AW'(len);
    rd_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    filter_size = AW'($urandom);
    stride = AW'($urandom);
    ifmap_len = AW'($urandom);
  endtask

  task automatic sweep(input int f, input int s,
                       input int len, input int rmode,
                       input bit inject);
    int cyc;
    int ph;
    int first;
    int last_pop;
    bit got_done;
    bit r;
    build_model(f, s, len);
    launch(f, s, len);
    check("load_valid", 32'(rd_valid), 0);
    check("load_busy", 32'(busy), 1);
    cyc = 1;
    ph = 0;
    first = -1;
    last_pop = -1;
    got_done = 1'b0;
    while (cyc < 2000 && !got_done) begin
      if (done) begin
        got_done = 1'b1;
        rd_ready = 1'b0;
      end else begin
        if (rd_valid) begin
          if (first < 0) first = cyc;
          if (q_addr.size() == 0) begin
            check("extra_beat", 1, 0);
          end else begin
            check("rd_addr", 32'(rd_addr), q_addr[0]);
            check("filter_addr", 32'(filter_addr), q_fa[0]);
            check("window_last", 32'(window_last),
                  q_last[0]);
          end
          r = ready_of(rmode, ph);
          ph++;
          rd_ready = r;
          if (r && q_addr.size() > 0) begin
            void'(q_addr.pop_front());
            void'(q_fa.pop_front());
            void'(q_last.pop_front());
            last_pop = cyc;
          end
        end else begin
          rd_ready = 1'($urandom_range(0, 1));
        end
        if (inject && cyc == 5) begin
          start = 1'b1;
          filter_size = AW'($urandom);
          stride = AW'($urandom);
          ifmap_len = AW'($urandom);
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check("done_seen", 32'(got_done), 1);
    check("beats_left", q_addr.size(), 0);
    check("fin_err", 32'(err), 32'(exp_err));
    check("fin_cnt", 32'(window_count), exp_cnt);
    check("fin_valid", 32'(rd_valid), 0);
    check("fin_busy", 32'(busy), 1);
    if (exp_err) begin
      check("degen_lat", cyc, 2);
      check("degen_nobeat", first, -1);
    end else begin
      check("first_lat", first, 2);
      check("done_lat", cyc - last_pop, 1);
    end
    @(negedge clk);
    check("idle_done", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_cnt", 32'(window_count), exp_cnt);
    check("idle_err", 32'(err), 32'(exp_err));
  endtask

  initial begin
    int pops;
    #12;
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    sweep(3, 1, 5, 0, 1'b0);
    sweep(3, 2, 7, 0, 1'b0);
    sweep(2, 1, 4, 1, 1'b0);
    sweep(0, 1, 4, 0, 1'b0);
    sweep(6, 1, 4, 0, 1'b0);
    sweep(3, 0, 5, 0, 1'b0);
    sweep(3, 1, 5, 0, 1'b1);
    sweep(31, 3, 31, 2, 1'b0);

    // Abort during the second window, then rerun cleanly.
    build_model(3, 1, 5);
    launch(3, 1, 5);
    rd_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 40 && pops < 4; i++) begin
      @(negedge clk);
      if (rd_valid) pops++;
    end
    check("abort_pops", pops, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_nodone", 32'(done), 0);
    end
    rst_n = 1'b1;
    sweep(3, 1, 5, 0, 1'b0);

    for (int k = 0; k < 25; k++) begin
      sweep($urandom_range(0, 8), $urandom_range(0, 4),
            $urandom_range(0, 31), $urandom_range(0, 2),
            1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/window_addr_gen.md
WINDOW_ADDR_GEN -- requirements
Module: window_addr_gen

Interface
REQ-001 Parameter ADDR_W, default 5, sets the width of every address, length, size and stride field.
REQ-002 Parameter CNT_W, default 8, sets the width of the window_count output.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 Port start, input, 1, one-cycle request to begin a sweep; sampled only in IDLE.
REQ-006 Port filter_size, input, ADDR_W, taps per window; latched on accepted start.
REQ-007 Port stride, input, ADDR_W, window base advance; latched on accepted start.
REQ-008 Port ifmap_len, input, ADDR_W, count of valid input-buffer entries; latched on accepted start.
REQ-009 Port rd_ready, input, 1, downstream consumer accepts the current beat.
REQ-010 Port rd_valid, output, 1, a valid read beat is presented.
REQ-011 Port rd_addr, output, ADDR_W, input-buffer address, equal to base + tap.
REQ-012 Port filter_addr, output, ADDR_W, filter-buffer address, equal to tap.
REQ-013 Port window_last, output, 1, the current beat is the final tap of a window.
REQ-014 Port window_count, output, CNT_W, number of windows fully transferred in the current sweep.
REQ-015 Port busy, output, 1, high in every state except IDLE.
REQ-016 Port done, output, 1, one-cycle pulse marking the end of a sweep.
REQ-017 Port err, output, 1, set with done when the sweep was degenerate; cleared on the next accepted start.

Function
REQ-018 The FSM SHALL have four states: IDLE, LOAD, RUN, FIN.
REQ-019 State transitions SHALL be as follows:
- IDLE -> LOAD on start.
- LOAD -> FIN if filter_size == 0 or filter_size > ifmap_len (set err); otherwise LOAD -> RUN with base = 0, tap = 0.
- RUN -> FIN after the last window's last beat handshakes.
- FIN -> IDLE unconditionally.
REQ-020 rd_valid SHALL be high only in RUN, so the first beat appears two cycles after start is sampled.
REQ-021 A beat SHALL transfer when rd_valid && rd_ready; with rd_ready low, rd_addr, filter_addr and window_last hold stable.
REQ-022 On each transfer, tap SHALL increment; when tap == filter_size-1, window_last is high for that beat, tap wraps to 0 and window_count increments.
REQ-023 On a window wrap, next_base = base + stride, computed in ADDR_W+2 bits with no truncation; RUN continues only if next_base + filter_size <= ifmap_len, else goes to FIN.
REQ-024 A stride of 0 SHALL be treated as 1.
REQ-025 done SHALL pulse high for exactly the FIN cycle; window_count holds its value until the next accepted start clears it.
REQ-026 start asserted while busy SHALL be ignored; changes to the inputs after latching have no effect.
REQ-027 window_count SHALL saturate at all-ones.

Reset
REQ-028 Asserting rst_n low SHALL, at any time, force IDLE and drive rd_valid=0, rd_addr=0, filter_addr=0, window_last=0, window_count=0, busy=0, done=0, err=0.
REQ-029 A reset asserted mid-sweep SHALL abandon the sweep without producing a done pulse.

Structure
REQ-030 The state enumeration and the default ADDR_W and CNT_W values SHALL reside in the shared package conv_ctrl_pkg.
REQ-031 Tap counting SHALL be a sub-module, window_tap_counter, with enable, wrap limit, count output and wrap flag; base and FSM logic stay in the top.

Verification
REQ-032 Scenario: filter 3, stride 1, len 5, rd_ready=1 -> rd_addr sequence 0,1,2,1,2,3,2,3,4; window_last on beats 3, 6 and 9; window_count=3; done one cycle after beat 9.
REQ-033 Scenario: filter 3, stride 2, len 7 -> bases 0, 2, 4; 9 beats; window_count=3; filter_addr cycles 0,1,2.
REQ-034 Scenario: filter 2, stride 1, len 4, with rd_ready toggled 1,0,0,1 repeatedly -> outputs stable while stalled; addresses 0,1,1,2,2,3; window_count=3.
REQ-035 Scenario: filter 0, len 4; then separately filter 6, len 4 -> no rd_valid; done and err high two cycles after start; window_count=0.
REQ-036 Scenario: rst_n pulsed low during the second window of REQ-032 -> all outputs zero at once, no done; a fresh start then repeats REQ-032 exactly.
REQ-037 Scenario: start re-asserted during RUN -> ignored; the sweep completes unchanged.
